bayer_frame_ctrl: RTL and testbench
===================================

BAYER_FRAME_CTRL -- requirements
Module: bayer_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, 320, pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, 466, lines per frame.
REQ-003 SHALL have parameter TIMEOUT_LIMIT, 1000000, maximum DRAIN cycles before abort.
REQ-004 SHALL have ports as follows.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse.
- abort  in  1  synchronous frame abort.
- pattern_in  in  2  Bayer pattern: 00 RGGB, 01 BGGR, 10 GRBG, 11 GBRG.
- src_valid  in  1  upstream pixel valid.
- src_data  in  8  upstream raw pixel.
- src_ready  out  1  upstream accept.
- dp_rst_n  out  1  active-low reset to demosaic datapath.
- dp_valid  out  1  datapath data_valid.
- dp_data  out  8  datapath bayer_data.
- dp_pattern  out  2  datapath pattern_select.
- dp_out_valid  in  1  datapath data_out_valid.
- busy  out  1  state != IDLE.
- col, row  out  CW, RW  position of next input pixel; CW = clog2(IMG_WIDTH), RW = clog2(IMG_HEIGHT).
- frame_done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle timeout pulse.

Function
REQ-005 SHALL implement states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-006 IDLE: start=1 SHALL latch pattern_in into dp_pattern and go to LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-007 LOAD: dp_rst_n SHALL be 0 for exactly 2 cycles, then 1; LOAD SHALL then go to RUN.
REQ-008 RUN: src_ready=1; dp_valid = src_valid; dp_data = src_data (combinational pass-through, zero latency).
REQ-009 Each accepted pixel (src_valid & src_ready) SHALL advance col; col wraps IMG_WIDTH-1 -> 0 and increments row.
REQ-010 Acceptance of pixel at col=IMG_WIDTH-1, row=IMG_HEIGHT-1 SHALL move to DRAIN next cycle.
REQ-011 DRAIN: src_ready=0, dp_valid=0, dp_data=0.
REQ-012 Output counter (18 bits) SHALL count dp_out_valid in RUN and DRAIN; counts in IDLE/LOAD/DONE SHALL be ignored.
REQ-013 Output count reaching IMG_WIDTH*IMG_HEIGHT SHALL move to DONE; if reached in RUN, FSM SHALL go to DONE after the last input is accepted.
REQ-014 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-015 abort=1 in any state SHALL go to IDLE next cycle, clear counters, hold dp_rst_n=0 for that one cycle; abort beats start in the same cycle.
REQ-016 dp_pattern SHALL stay stable from LOAD through DONE; it changes only on accepted start.

Reset
REQ-017 rst=1 SHALL force IDLE and zero col, row, and counters.
REQ-018 rst=1 SHALL drive src_ready=0, dp_valid=0, dp_data=0, dp_pattern=00, dp_rst_n=0, busy=0, frame_done=0, timeout_err=0.
REQ-019 rst mid-frame SHALL discard the frame, with no frame_done pulse.

Configuration
REQ-020 With BAYER_FRAME_CTRL_TIMEOUT_EN defined, a DRAIN cycle counter SHALL reach TIMEOUT_LIMIT, pulse timeout_err for 1 cycle, and return to IDLE without frame_done.
REQ-021 Without BAYER_FRAME_CTRL_TIMEOUT_EN, there SHALL be no timeout counter, DRAIN SHALL wait indefinitely, and timeout_err SHALL be tied to 0.

Structure
REQ-022 Shared package bayer_pkg SHALL hold the FSM state enum, the four pattern codes, and the IMG_SIZE and counter-width constants.
REQ-023 Sub-module bayer_pos_counter (col/row wrap counter with last-pixel flag) SHALL be instantiated once.

Verification
REQ-024 The bench SHALL cover these directed scenarios.
- Reset, then start with pattern 10: dp_rst_n low exactly 2 cycles, dp_pattern=10, busy=1.
- Stream 149120 pixels with src_valid always 1: DRAIN entered the cycle after pixel 149119; col/row wrap at 319/465.
- Datapath model emitting 149120 outputs 2*320+5 cycles late: single frame_done pulse, then IDLE, busy=0.
- src_valid toggling 1-0: col advances only on accepted beats; dp_valid mirrors src_valid.
- abort at row 100, and rst mid-DRAIN: IDLE next cycle, counters 0, no frame_done; a new start then works.
- TIMEOUT_EN, TIMEOUT_LIMIT=50, no outputs: timeout_err pulse 50 cycles after DRAIN entry; without the macro, FSM still in DRAIN after 1000 cycles.

Source files
------------

// File: rtl/bayer_pkg.sv
// ---------------------------------------------------------------------------
// bayer_pkg
// Shared definitions for the Bayer frame controller:
//   - state_t      : controller FSM states
//   - PAT_*        : the four Bayer pattern_select codes
//   - IMG_*_DEF    : default frame geometry and total pixel count
//   - OCNT_W       : width of the datapath output counter
//   - LOAD_CYCLES  : cycles the datapath is held in reset before a frame
// ---------------------------------------------------------------------------
package bayer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] PAT_RGGB = 2'b00;
  localparam logic [1:0] PAT_BGGR = 2'b01;
  localparam logic [1:0] PAT_GRBG = 2'b10;
  localparam logic [1:0] PAT_GBRG = 2'b11;

  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_HEIGHT_DEF = 466;
  localparam int IMG_SIZE       = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

  // 18 bits covers the default 320x466 = 149120 pixel frame.
  localparam int OCNT_W = 18;

  localparam int LOAD_CYCLES = 2;

endpackage

// File: rtl/bayer_pos_counter.sv
// ---------------------------------------------------------------------------
// bayer_pos_counter
// Column/row position of the next input pixel. Column wraps WIDTH-1 -> 0 and
// bumps the row; the row wraps HEIGHT-1 -> 0. o_last flags the final pixel
// of the frame so the controller can leave RUN on its acceptance.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : synchronous clear to (0,0), wins over i_adv
//   i_adv     : advance by one pixel
//   o_col     : current column
//   o_row     : current row
//   o_last    : position is (WIDTH-1, HEIGHT-1)
// ---------------------------------------------------------------------------
module bayer_pos_counter
  import bayer_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH_DEF,
  parameter int HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_adv,
  output logic [$clog2(WIDTH)-1:0]  o_col,
  output logic [$clog2(HEIGHT)-1:0] o_row,
  output logic                      o_last
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_col_wrap = (r_col == COL_MAX);
  assign w_row_wrap = (r_row == ROW_MAX);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_wrap && w_row_wrap;

endmodule

// File: rtl/bayer_frame_ctrl.sv
// ---------------------------------------------------------------------------
// bayer_frame_ctrl
// Sequences one raw Bayer frame into a demosaic datapath:
//   IDLE -> LOAD (datapath reset, 2 cycles) -> RUN (pixel pass-through)
//   -> DRAIN (wait for remaining datapath outputs) -> DONE (1 cycle) -> IDLE
// abort returns to IDLE from any state and pulses dp_rst_n low once.
//
// Handshake: a pixel is transferred on a cycle where src_valid && src_ready;
// src_ready is high only in RUN and does not depend on src_valid.
//
// Optional build macro BAYER_FRAME_CTRL_TIMEOUT_EN: adds a DRAIN cycle
// counter that gives up after TIMEOUT_LIMIT cycles, pulsing timeout_err.
// Without it DRAIN waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, abort          : frame start pulse, synchronous abort
//   pattern_in            : Bayer pattern latched on accepted start
//   src_valid/data/ready  : upstream pixel stream
//   dp_rst_n              : active-low datapath reset
//   dp_valid, dp_data     : pixel to datapath (combinational from src)
//   dp_pattern            : pattern_select to datapath
//   dp_out_valid          : datapath output strobe (counted in RUN/DRAIN)
//   busy                  : not IDLE
//   col, row              : position of next input pixel
//   frame_done            : one-cycle completion pulse (DONE state)
//   timeout_err           : one-cycle DRAIN timeout pulse
//   dbg_state             : current FSM state encoding (state_t)
// ---------------------------------------------------------------------------
module bayer_frame_ctrl
  import bayer_pkg::*;
#(
  parameter int IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT    = IMG_HEIGHT_DEF,
  parameter int TIMEOUT_LIMIT = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    pattern_in,
  input  logic                          src_valid,
  input  logic [7:0]                    src_data,
  output logic                          src_ready,
  output logic                          dp_rst_n,
  output logic                          dp_valid,
  output logic [7:0]                    dp_data,
  output logic [1:0]                    dp_pattern,
  input  logic                          dp_out_valid,
  output logic                          busy,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic                          frame_done,
  output logic                          timeout_err,
  output logic [2:0]                    dbg_state
);

  localparam logic [OCNT_W-1:0] FRAME_PIXELS = OCNT_W'(IMG_WIDTH * IMG_HEIGHT);

  state_t              r_state;
  state_t              w_next;
  logic                r_load_cnt;
  logic [OCNT_W-1:0]   r_ocnt;
  logic [OCNT_W-1:0]   w_ocnt_next;
  logic                r_dp_hold;
  logic [1:0]          r_pattern;
  logic                w_run;
  logic                w_accept;
  logic                w_cnt_en;
  logic                w_out_full;
  logic                w_last;
  logic                w_start_acc;
  logic                w_timeout;

  assign w_run       = (r_state == ST_RUN);
  assign w_accept    = w_run && src_valid;
  assign w_start_acc = (r_state == ST_IDLE) && start && !abort;
  assign w_cnt_en    = dp_out_valid && (w_run || (r_state == ST_DRAIN));
  assign w_ocnt_next = r_ocnt + OCNT_W'(w_cnt_en);
  // Includes this cycle's output so DONE follows the last output directly.
  assign w_out_full  = (w_ocnt_next >= FRAME_PIXELS);

  bayer_pos_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .i_clear (abort || (r_state == ST_IDLE)),
    .i_adv   (w_accept),
    .o_col   (col),
    .o_row   (row),
    .o_last  (w_last)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (r_load_cnt) w_next = ST_RUN;
      // If the datapath already produced the whole frame, skip DRAIN.
      ST_RUN:   if (w_accept && w_last) w_next = w_out_full ? ST_DONE : ST_DRAIN;
      ST_DRAIN: begin
        if (w_out_full)     w_next = ST_DONE;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_load_cnt <= 1'b0;
      r_ocnt     <= '0;
      r_dp_hold  <= 1'b1;
      r_pattern  <= PAT_RGGB;
    end else begin
      r_state    <= w_next;
      // One low cycle on dp_rst_n in the cycle after an abort.
      r_dp_hold  <= abort;
      r_load_cnt <= ((r_state == ST_LOAD) && !abort) ? ~r_load_cnt : 1'b0;
      if (w_start_acc) r_pattern <= pattern_in;
      if (abort || (r_state == ST_IDLE)) r_ocnt <= '0;
      else                               r_ocnt <= w_ocnt_next;
    end
  end

`ifdef BAYER_FRAME_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_LIMIT + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_timeout_err;

  // r_tcnt is 0 in the first DRAIN cycle, so the pulse lands exactly
  // TIMEOUT_LIMIT cycles after DRAIN entry, together with IDLE.
  assign w_timeout = (r_state == ST_DRAIN) && (r_tcnt == TW'(TIMEOUT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout && !w_out_full && !abort;
      if ((r_state == ST_DRAIN) && !abort) r_tcnt <= r_tcnt + TW'(1);
      else                                 r_tcnt <= '0;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_LIMIT > 0);
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign src_ready  = w_run;
  assign dp_valid   = w_accept;
  assign dp_data    = w_run ? src_data : 8'd0;
  assign dp_pattern = r_pattern;
  assign dp_rst_n   = !((r_state == ST_LOAD) || r_dp_hold);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bayer_frame_ctrl
// Directed bench for bayer_frame_ctrl on a reduced 10x5 frame. Stimulus pushes
// expected pixels {row, col, data} and expected frame_done cycles into
// queues; a negedge monitor pops and compares whenever the DUT presents
// dp_valid or frame_done. A shift-register datapath model returns one
// dp_out_valid per pixel 2*W+5 cycles later. Build with
// BAYER_FRAME_CTRL_TIMEOUT_EN to exercise the DRAIN timeout.
// ---------------------------------------------------------------------------
module tb_bayer_frame_ctrl;
  import bayer_pkg::*;

  localparam int W   = 10;
  localparam int H   = 5;
  localparam int N   = W * H;
  localparam int LAT = 2 * W + 5;
  localparam int TOL = 50;
  localparam int CW  = $clog2(W);
  localparam int RW  = $clog2(H);
  localparam int EW  = RW + CW + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    pattern_in = 2'b00;
  logic          src_valid = 1'b0;
  logic [7:0]    src_data = 8'd0;
  logic          src_ready;
  logic          dp_rst_n;
  logic          dp_valid;
  logic [7:0]    dp_data;
  logic [1:0]    dp_pattern;
  logic          dp_out_valid;
  logic          busy;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          frame_done;
  logic          timeout_err;
  logic [2:0]    dbg_state;

  bayer_frame_ctrl #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .TIMEOUT_LIMIT (TOL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pattern_in   (pattern_in),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .dp_rst_n     (dp_rst_n),
    .dp_valid     (dp_valid),
    .dp_data      (dp_data),
    .dp_pattern   (dp_pattern),
    .dp_out_valid (dp_out_valid),
    .busy         (busy),
    .col          (col),
    .row          (row),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- datapath model ----------------
  logic           model_en = 1'b1;
  logic [LAT-1:0] r_dp_sr;
  always @(posedge clk) begin
    if (!dp_rst_n) r_dp_sr <= '0;
    else           r_dp_sr <= {r_dp_sr[LAT-2:0], dp_valid & model_en};
  end
  assign dp_out_valid = r_dp_sr[LAT-1];

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  int            done_q[$];
  logic          seen_done = 1'b0;
  logic          tout_window = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
  endtask

  initial forever begin
    logic [EW-1:0] e;
    int            d;
    @(negedge clk);
    if (dp_valid === 1'b1) begin
      if (exp_q.size() == 0) fail_now("unexpected_pixel", {24'd0, dp_data});
      else begin
        e = exp_q.pop_front();
        check("pix_data", {24'd0, dp_data}, {24'd0, e[7:0]});
        check("pix_col",  32'(col), 32'(e[CW+7:8]));
        check("pix_row",  32'(row), 32'(e[EW-1:CW+8]));
      end
    end
    if (frame_done === 1'b1) begin
      seen_done = 1'b1;
      if (done_q.size() == 0) fail_now("unexpected_done", 32'(cyc));
      else begin
        d = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(d));
      end
    end
    if (timeout_err === 1'b1 && !tout_window) fail_now("unexpected_timeout", 32'(cyc));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] pat);
    start = 1'b1;
    pattern_in = pat;
    tick();
    start = 1'b0;
    pattern_in = ~pat;
    check("load_state",   32'(dbg_state), 32'(ST_LOAD));
    check("load_rst_n_1", 32'(dp_rst_n), 32'd0);
    check("load_busy",    32'(busy), 32'd1);
    check("load_pattern", 32'(dp_pattern), 32'(pat));
    tick();
    check("load_rst_n_2", 32'(dp_rst_n), 32'd0);
    tick();
    check("run_rst_n",    32'(dp_rst_n), 32'd1);
    check("run_state",    32'(dbg_state), 32'(ST_RUN));
    check("run_ready",    32'(src_ready), 32'd1);
  endtask

  // Full frame with src_valid held high; a stray start mid-frame must be ignored.
  task automatic stream_frame(output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < N; i++) begin
      src_valid = 1'b1;
      src_data  = 8'(i * 7 + 3);
      exp_q.push_back({RW'(i / W), CW'(i % W), src_data});
      if (i == N - 1) last_cyc = cyc;
      if (i == 3) begin
        start = 1'b1;
        pattern_in = PAT_GBRG;
      end else begin
        start = 1'b0;
      end
      tick();
      if (i == W - 1) begin
        check("wrap_col", 32'(col), 32'd0);
        check("wrap_row", 32'(row), 32'd1);
      end
    end
    src_valid = 1'b0;
    src_data  = 8'd0;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      if (seen_done) break;
      tick();
    end
    check("done_seen", 32'(seen_done), 32'd1);
    seen_done = 1'b0;
    check("post_done_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_done_busy",  32'(busy), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int last_cyc;
    int acc;
    int j;

    // Reset values.
    repeat (3) tick();
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_ready",   32'(src_ready), 32'd0);
    check("rst_dvalid",  32'(dp_valid), 32'd0);
    check("rst_ddata",   32'(dp_data), 32'd0);
    check("rst_pattern", 32'(dp_pattern), 32'd0);
    check("rst_rst_n",   32'(dp_rst_n), 32'd0);
    check("rst_done",    32'(frame_done), 32'd0);
    check("rst_tout",    32'(timeout_err), 32'd0);
    check("rst_col",     32'(col), 32'd0);
    check("rst_row",     32'(row), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_rst_n",  32'(dp_rst_n), 32'd1);
    check("idle_state",  32'(dbg_state), 32'(ST_IDLE));

    // Frame 1: pattern GRBG, continuous stream, datapath model on.
    start_frame(PAT_GRBG);
    stream_frame(last_cyc);
    check("drain_entry", 32'(dbg_state), 32'(ST_DRAIN));
    check("drain_ready", 32'(src_ready), 32'd0);
    check("drain_dvalid", 32'(dp_valid), 32'd0);
    check("drain_col",   32'(col), 32'd0);
    check("drain_row",   32'(row), 32'd0);
    check("drain_pattern", 32'(dp_pattern), 32'(PAT_GRBG));
    done_q.push_back(last_cyc + LAT + 1);
    wait_done();

    // Frame 2: src_valid toggling, then abort at row 2 (24 pixels accepted).
    start_frame(PAT_RGGB);
    acc = 0;
    j = 0;
    while (acc < 2 * W + 4 && j < 200) begin
      if (j % 2 == 0) begin
        src_valid = 1'b1;
        src_data  = 8'(8'hA0 + acc);
        exp_q.push_back({RW'(acc / W), CW'(acc % W), src_data});
        acc++;
      end else begin
        src_valid = 1'b0;
        src_data  = 8'hFF;
        #1;
        check("tog_dvalid", 32'(dp_valid), 32'd0);
        check("tog_col",    32'(col), 32'(acc % W));
      end
      j++;
      tick();
    end
    src_valid = 1'b0;
    check("tog_col_end", 32'(col), 32'd4);
    check("tog_row_end", 32'(row), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_col",   32'(col), 32'd0);
    check("abort_row",   32'(row), 32'd0);
    check("abort_rst_n", 32'(dp_rst_n), 32'd0);
    tick();
    check("abort_rst_n_rel", 32'(dp_rst_n), 32'd1);

    // abort beats start in the same cycle.
    start = 1'b1;
    abort = 1'b1;
    pattern_in = PAT_GBRG;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_state",   32'(dbg_state), 32'(ST_IDLE));
    check("abort_start_pattern", 32'(dp_pattern), 32'(PAT_RGGB));
    tick();

    // Frame 3: no datapath outputs, rst mid-DRAIN.
    model_en = 1'b0;
    start_frame(PAT_BGGR);
    stream_frame(last_cyc);
    check("f3_drain", 32'(dbg_state), 32'(ST_DRAIN));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state",   32'(dbg_state), 32'(ST_IDLE));
    check("mrst_busy",    32'(busy), 32'd0);
    check("mrst_col",     32'(col), 32'd0);
    check("mrst_row",     32'(row), 32'd0);
    check("mrst_rst_n",   32'(dp_rst_n), 32'd0);
    check("mrst_pattern", 32'(dp_pattern), 32'(PAT_RGGB));
    tick();

    // Frame 4: no datapath outputs, DRAIN timeout behaviour.
    start_frame(PAT_GBRG);
    stream_frame(last_cyc);
    check("f4_drain", 32'(dbg_state), 32'(ST_DRAIN));
`ifdef BAYER_FRAME_CTRL_TIMEOUT_EN
    tout_window = 1'b1;
    for (int k = 1; k < TOL; k++) begin
      tick();
      check("tout_early", 32'(timeout_err), 32'd0);
    end
    check("tout_still_drain", 32'(dbg_state), 32'(ST_DRAIN));
    tick();
    check("tout_pulse", 32'(timeout_err), 32'd1);
    check("tout_state", 32'(dbg_state), 32'(ST_IDLE));
    check("tout_done",  32'(frame_done), 32'd0);
    tick();
    tout_window = 1'b0;
    check("tout_pulse_end", 32'(timeout_err), 32'd0);
`else
    repeat (1000) tick();
    check("drain_wait_state", 32'(dbg_state), 32'(ST_DRAIN));
    check("drain_wait_tout",  32'(timeout_err), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("drain_abort_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
`endif

    // Frame 5: a fresh start after abort/reset completes normally.
    model_en = 1'b1;
    start_frame(PAT_BGGR);
    stream_frame(last_cyc);
    done_q.push_back(last_cyc + LAT + 1);
    wait_done();
    check("f5_pattern", 32'(dp_pattern), 32'(PAT_BGGR));

    repeat (3) tick();
    check("exp_q_empty",  32'(exp_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
